drop_timer: RTL and testbench

Gravity and lock-delay scheduler for the Tetris game core. It generates single-cycle `fall_tick` pulses at a rate set by the current level, with an optional soft-drop override. When the active piece has landed, it runs a lock-delay window and emits `lock_tick`. All timing runs in the `clk` domain as enable pulses, so game logic never consumes a divided clock.

---
 rtl/drop_timer.sv | 182 ++++++++++++++++++
 tb/tb_drop_timer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/drop_timer.sv
// Gravity and lock-delay scheduler: emits fall_tick / lock_tick enable pulses in the clk domain.
// Optional soft-drop override is compiled in when DROP_TIMER_SOFT_DROP_EN is defined.
module drop_timer #(
    parameter int unsigned BASE_PERIOD = 100_000_000,
    parameter int unsigned STEP        = 8_000_000,
    parameter int unsigned MIN_PERIOD  = 5_000_000,
    parameter int unsigned SOFT_PERIOD = 5_000_000,
    parameter int unsigned LOCK_PERIOD = 50_000_000,
    parameter int unsigned MAX_RESETS  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [4:0] level,
    input  logic       soft_drop,
    input  logic       landed,
    input  logic       move_reset,
    output logic       fall_tick,
    output logic       lock_tick,
    output logic       running,
    output logic       paused
);

    localparam logic [31:0] BASE_C    = 32'(BASE_PERIOD);
    localparam logic [31:0] STEP_C    = 32'(STEP);
    localparam logic [31:0] MIN_C     = 32'(MIN_PERIOD);
    localparam logic [31:0] LOCK_M1_C = 32'(LOCK_PERIOD) - 32'd1;
    localparam logic [31:0] MAXR_C    = 32'(MAX_RESETS);
    localparam logic [31:0] HEADROOM_C = BASE_C - MIN_C;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FALL = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] lcnt_q, lcnt_d;
    logic [3:0]  resets_used_q, resets_used_d;
    logic        fall_tick_q, fall_tick_d;
    logic        lock_tick_q, lock_tick_d;
    logic        running_q, running_d;
    logic        paused_q, paused_d;

    logic [31:0] lvl_prod_s;
    logic [31:0] p_lvl_s;
    logic [31:0] period_s;
    logic [31:0] period_m1_s;
    logic        resets_left_s;

    // Level-derived fall period, clamped at the floor before it can underflow.
    always_comb begin
        lvl_prod_s = {27'd0, level} * STEP_C;
        if (lvl_prod_s > HEADROOM_C) begin
            p_lvl_s = MIN_C;
        end else begin
            p_lvl_s = BASE_C - lvl_prod_s;
        end
    end

`ifdef DROP_TIMER_SOFT_DROP_EN
    // Soft drop only ever speeds the piece up, never slows it down.
    always_comb begin
        if (soft_drop && (32'(SOFT_PERIOD) < p_lvl_s)) begin
            period_s = 32'(SOFT_PERIOD);
        end else begin
            period_s = p_lvl_s;
        end
    end
`else
    logic soft_drop_unused_s;
    assign soft_drop_unused_s = soft_drop;

    // Without the override the level period is used directly.
    always_comb begin
        period_s = p_lvl_s;
    end
`endif

    assign period_m1_s   = period_s - 32'd1;
    assign resets_left_s = ({28'd0, resets_used_q} < MAXR_C);

    // Next-state, counter and pulse logic; stop outranks start, start outranks state behaviour.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lcnt_d        = lcnt_q;
        resets_used_d = resets_used_q;
        fall_tick_d   = 1'b0;
        lock_tick_d   = 1'b0;

        if (stop) begin
            state_d       = ST_IDLE;
            cnt_d         = 32'd0;
            lcnt_d        = 32'd0;
            resets_used_d = 4'd0;
        end else if (start) begin
            state_d       = ST_FALL;
            cnt_d         = 32'd0;
            lcnt_d        = 32'd0;
            resets_used_d = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FALL: begin
                    if (pause) begin
                        state_d = ST_FALL;
                    end else if (landed) begin
                        state_d       = ST_LOCK;
                        lcnt_d        = 32'd0;
                        resets_used_d = 4'd0;
                    end else if (cnt_q >= period_m1_s) begin
                        cnt_d       = 32'd0;
                        fall_tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                ST_LOCK: begin
                    if (pause) begin
                        state_d = ST_LOCK;
                    end else if (!landed) begin
                        state_d = ST_FALL;
                        cnt_d   = 32'd0;
                    end else if (move_reset && resets_left_s) begin
                        lcnt_d        = 32'd0;
                        resets_used_d = resets_used_q + 4'd1;
                    end else if (lcnt_q == LOCK_M1_C) begin
                        lock_tick_d = 1'b1;
                        state_d     = ST_FALL;
                        cnt_d       = 32'd0;
                    end else begin
                        lcnt_d = lcnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d       = ST_IDLE;
                    cnt_d         = 32'd0;
                    lcnt_d        = 32'd0;
                    resets_used_d = 4'd0;
                end
            endcase
        end

        running_d = (state_d != ST_IDLE);
        paused_d  = (state_d != ST_IDLE) && pause;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 32'd0;
            lcnt_q        <= 32'd0;
            resets_used_q <= 4'd0;
            fall_tick_q   <= 1'b0;
            lock_tick_q   <= 1'b0;
            running_q     <= 1'b0;
            paused_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lcnt_q        <= lcnt_d;
            resets_used_q <= resets_used_d;
            fall_tick_q   <= fall_tick_d;
            lock_tick_q   <= lock_tick_d;
            running_q     <= running_d;
            paused_q      <= paused_d;
        end
    end

    assign fall_tick = fall_tick_q;
    assign lock_tick = lock_tick_q;
    assign running   = running_q;
    assign paused    = paused_q;

endmodule

// File: tb/tb_drop_timer.sv
// Scoreboard bench for drop_timer: stimulus queues expected tick events (kind, cycle),
// a negedge monitor pops and compares every pulse the DUT emits.
module tb_drop_timer;

`ifdef DROP_TIMER_SOFT_DROP_EN
    localparam int SP = 3;
`else
    localparam int SP = 20;
`endif

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, soft_drop, landed, move_reset;
    logic [4:0] level;
    logic       fall_tick, lock_tick, running, paused;

    typedef struct {
        bit is_lock;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t;

    drop_timer #(
        .BASE_PERIOD(20), .STEP(4), .MIN_PERIOD(5),
        .SOFT_PERIOD(3), .LOCK_PERIOD(10), .MAX_RESETS(2)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .level(level), .soft_drop(soft_drop), .landed(landed),
        .move_reset(move_reset), .fall_tick(fall_tick), .lock_tick(lock_tick),
        .running(running), .paused(paused)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_tick(input bit is_lock, input int c);
        exp_t e;
        e.is_lock = is_lock;
        e.cyc     = c;
        q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest expected event exactly.
    always @(negedge clk) begin
        exp_t e;
        if (fall_tick !== 1'b0 || lock_tick !== 1'b0) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick: fall=%0b lock=%0b at cycle %0d, no tick expected",
                         fall_tick, lock_tick, cyc);
            end else begin
                e = q.pop_front();
                if (fall_tick === lock_tick || lock_tick !== e.is_lock || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL tick_event: got fall=%0b lock=%0b at cycle %0d, expected %s at cycle %0d",
                             fall_tick, lock_tick, cyc, e.is_lock ? "lock" : "fall", e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        soft_drop = 1'b0; landed = 1'b0; move_reset = 1'b0; level = 5'd0;
        step(3);
        chk("reset_fall_tick", fall_tick, 1'b0);
        chk("reset_lock_tick", lock_tick, 1'b0);
        chk("reset_running", running, 1'b0);
        chk("reset_paused", paused, 1'b0);
        rst = 1'b0;

        // pause and landed ignored in IDLE
        pause = 1'b1; landed = 1'b1;
        step(2);
        chk("idle_paused", paused, 1'b0);
        chk("idle_running", running, 1'b0);
        pause = 1'b0; landed = 1'b0;

        // stop beats start
        start = 1'b1; stop = 1'b1;
        step(1);
        start = 1'b0; stop = 1'b0;
        step(1);
        chk("start_stop_running", running, 1'b0);
        step(25);

        // level 0 -> 20, level 3 -> 8, level 9 and 31 clamp to 5
        start = 1'b1;
        step(1);
        start = 1'b0;
        t = cyc;
        chk("start_running", running, 1'b1);
        expect_tick(1'b0, t + 20);
        expect_tick(1'b0, t + 40);
        step(40);
        level = 5'd3;
        expect_tick(1'b0, t + 48);
        expect_tick(1'b0, t + 56);
        step(16);
        level = 5'd9;
        expect_tick(1'b0, t + 61);
        expect_tick(1'b0, t + 66);
        step(10);
        level = 5'd31;
        expect_tick(1'b0, t + 71);
        step(5);

        // soft drop (3 when enabled, otherwise level period 20), then release
        level = 5'd0; soft_drop = 1'b1;
        t = cyc;
        expect_tick(1'b0, t + SP);
        expect_tick(1'b0, t + 2 * SP);
        step(2 * SP);
        soft_drop = 1'b0;
        t = cyc;
        expect_tick(1'b0, t + 20);
        step(20);

        // pause 7 cycles mid-count: next tick 27 cycles after the previous one
        t = cyc;
        expect_tick(1'b0, t + 27);
        step(5);
        pause = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("paused_high", paused, 1'b1);
        end
        pause = 1'b0;
        step(1);
        chk("paused_released", paused, 1'b0);
        step(14);

        // lock delay with resets at +4, +8, +12 (third exceeds MAX_RESETS)
        landed = 1'b1;
        step(1);
        t = cyc;
        expect_tick(1'b1, t + 18);
        expect_tick(1'b0, t + 38);
        for (int r = 0; r < 3; r++) begin
            step(3);
            move_reset = 1'b1;
            step(1);
            move_reset = 1'b0;
        end
        chk("lock_running", running, 1'b1);
        step(6);
        landed = 1'b0;
        step(20);

        // slide-off at lcnt = 6
        landed = 1'b1;
        step(1);
        t = cyc;
        step(6);
        landed = 1'b0;
        expect_tick(1'b0, t + 27);
        step(21);

        // reset during LOCK: no pulses until a new start
        landed = 1'b1;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("rst_running", running, 1'b0);
        chk("rst_paused", paused, 1'b0);
        chk("rst_fall_tick", fall_tick, 1'b0);
        chk("rst_lock_tick", lock_tick, 1'b0);
        step(30);
        landed = 1'b0;

        start = 1'b1;
        step(1);
        start = 1'b0;
        t = cyc;
        expect_tick(1'b0, t + 20);
        step(22);

        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_ticks: %0d expected ticks never seen, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
